// File: rtl/pps_divider_mc_if.sv
// Signal bundle between the PPS conditioning/control side and pps_divider_mc:
// raw PPS, per-channel control and configuration in, pulse outputs and status out.
interface pps_divider_mc_if #(
    parameter int NUM_CH  = 2,
    parameter int DIV_W   = 8,
    parameter int PHASE_W = 32,
    parameter int WIDTH_W = 16,
    parameter int CNT_W   = 16
);
    logic                       i_pps_raw;
    logic [NUM_CH-1:0]          i_start;
    logic [NUM_CH-1:0]          i_stop;
    logic [NUM_CH-1:0]          i_periodic;
    logic [NUM_CH*DIV_W-1:0]    i_div_number;
    logic [NUM_CH*PHASE_W-1:0]  i_phase_us;
    logic [NUM_CH*WIDTH_W-1:0]  i_width_us;
    logic [NUM_CH*CNT_W-1:0]    i_pulse_count;
    logic [NUM_CH-1:0]          o_pps_divided;
    logic [NUM_CH-1:0]          o_busy;
    logic [NUM_CH-1:0]          o_done;
    logic [NUM_CH-1:0]          o_overrun;
    logic                       o_pps_missing;

    modport master (
        output i_pps_raw, i_start, i_stop, i_periodic, i_div_number,
               i_phase_us, i_width_us, i_pulse_count,
        input  o_pps_divided, o_busy, o_done, o_overrun, o_pps_missing
    );

    modport slave (
        input  i_pps_raw, i_start, i_stop, i_periodic, i_div_number,
               i_phase_us, i_width_us, i_pulse_count,
        output o_pps_divided, o_busy, o_done, o_overrun, o_pps_missing
    );
endinterface

// File: rtl/pps_divider_mc.sv
// Multi-channel PPS divider: one shared PPS synchroniser/edge detector and timeout
// monitor feeding NUM_CH independent pulse-generator FSMs with phase, width and count.
module pps_divider_mc #(
    parameter int NUM_CH           = 2,
    parameter int CLKS_PER_US      = 10,
    parameter int DIV_W            = 8,
    parameter int PHASE_W          = 32,
    parameter int WIDTH_W          = 16,
    parameter int CNT_W            = 16,
    parameter int PPS_TIMEOUT_CLKS = 12000000
) (
    input  logic            i_clk_10,
    input  logic            i_rst_n,
    pps_divider_mc_if.slave bus
);
    localparam int DLY_W = PHASE_W + 8;
    localparam int WID_W = WIDTH_W + 8;
    localparam int TMO_W = $clog2(PPS_TIMEOUT_CLKS + 1);
    localparam logic [DLY_W-1:0] CLK_DLY   = DLY_W'(CLKS_PER_US);
    localparam logic [WID_W-1:0] CLK_WID   = WID_W'(CLKS_PER_US);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(PPS_TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0] TMO_MAX   = {TMO_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_EDGE = 3'd2,
        ST_PHASE     = 3'd3,
        ST_HIGH      = 3'd4,
        ST_DONE      = 3'd5
    } ch_state_e;

    logic             pps_s1_r;
    logic             pps_s2_r;
    logic             pps_s3_r;
    logic             pps_edge_s;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [TMO_W-1:0] tmo_cnt_s;
    logic             pps_missing_r;

    // Synchronise raw PPS and track clocks since the last edge
    always_ff @(posedge i_clk_10) begin
        if (!i_rst_n) begin
            pps_s1_r      <= 1'b0;
            pps_s2_r      <= 1'b0;
            pps_s3_r      <= 1'b0;
            tmo_cnt_r     <= TMO_W'(0);
            pps_missing_r <= 1'b0;
        end else begin
            pps_s1_r      <= bus.i_pps_raw;
            pps_s2_r      <= pps_s1_r;
            pps_s3_r      <= pps_s2_r;
            tmo_cnt_r     <= tmo_cnt_s;
            pps_missing_r <= (tmo_cnt_s >= TMO_LIMIT);
        end
    end

    assign pps_edge_s = pps_s2_r & ~pps_s3_r;

    // Saturating timeout counter, cleared by every PPS edge
    always_comb begin
        tmo_cnt_s = tmo_cnt_r;
        if (pps_edge_s) begin
            tmo_cnt_s = TMO_W'(0);
        end else if (tmo_cnt_r != TMO_MAX) begin
            tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_s = tmo_cnt_r;
        end
    end

    assign bus.o_pps_missing = pps_missing_r;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        ch_state_e          state_r, state_s, run_state_s;
        logic [DIV_W-1:0]   div_r, div_s, div_cnt_r, div_cnt_s, div_step_s, cfg_div_s;
        logic [PHASE_W-1:0] phase_r, phase_s;
        logic [WIDTH_W-1:0] width_r, width_s;
        logic               periodic_r, periodic_s;
        logic [CNT_W-1:0]   count_r, count_s, pulses_r, pulses_s, pulses_inc_s;
        logic [DLY_W-1:0]   dly_cnt_r, dly_cnt_s, dly_load_s;
        logic [WID_W-1:0]   wid_cnt_r, wid_cnt_s, wid_load_s;
        logic               div_wrap_s, start_s, stop_s;
        logic               out_r, out_s, busy_r, busy_s, done_r, done_s, overrun_r, overrun_s;

        assign start_s      = bus.i_start[ch];
        assign stop_s       = bus.i_stop[ch];
        assign cfg_div_s    = bus.i_div_number[ch*DIV_W +: DIV_W];
        assign div_wrap_s   = (div_cnt_r == (div_r - DIV_W'(1)));
        assign div_step_s   = div_wrap_s ? DIV_W'(0) : (div_cnt_r + DIV_W'(1));
        assign pulses_inc_s = pulses_r + CNT_W'(1);
        assign dly_load_s   = ({8'b0, phase_r} * CLK_DLY) - DLY_W'(1);
        // A zero width still spends one cycle in HIGH so the pulse is counted
        assign wid_load_s   = (width_r == WIDTH_W'(0)) ? WID_W'(0)
                                                       : (({8'b0, width_r} * CLK_WID) - WID_W'(1));

        // Channel next-state, counters and registered-output values
        always_comb begin
            run_state_s = state_r;
            div_s       = div_r;
            phase_s     = phase_r;
            width_s     = width_r;
            periodic_s  = periodic_r;
            count_s     = count_r;
            div_cnt_s   = div_cnt_r;
            pulses_s    = pulses_r;
            dly_cnt_s   = dly_cnt_r;
            wid_cnt_s   = wid_cnt_r;
            overrun_s   = overrun_r;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_s && !stop_s) begin
                        run_state_s = ST_ARM;
                        div_s       = (cfg_div_s == DIV_W'(0)) ? DIV_W'(1) : cfg_div_s;
                        phase_s     = bus.i_phase_us[ch*PHASE_W +: PHASE_W];
                        width_s     = bus.i_width_us[ch*WIDTH_W +: WIDTH_W];
                        periodic_s  = bus.i_periodic[ch];
                        count_s     = bus.i_pulse_count[ch*CNT_W +: CNT_W];
                        overrun_s   = 1'b0;
                        div_cnt_s   = DIV_W'(0);
                        pulses_s    = CNT_W'(0);
                    end else begin
                        run_state_s = state_r;
                    end
                end
                ST_ARM, ST_WAIT_EDGE: begin
                    if (pps_edge_s) begin
                        div_cnt_s = (state_r == ST_ARM) ? DIV_W'(0) : div_step_s;
                        if ((state_r == ST_ARM) || div_wrap_s) begin
                            if (phase_r == PHASE_W'(0)) begin
                                run_state_s = ST_HIGH;
                                wid_cnt_s   = wid_load_s;
                            end else begin
                                run_state_s = ST_PHASE;
                                dly_cnt_s   = dly_load_s;
                            end
                        end else begin
                            run_state_s = state_r;
                        end
                    end else begin
                        run_state_s = state_r;
                    end
                end
                ST_PHASE, ST_HIGH: begin
                    // Edges keep the divider aligned; a qualifying one here is dropped
                    if (pps_edge_s) begin
                        div_cnt_s = div_step_s;
                        overrun_s = overrun_r | div_wrap_s;
                    end else begin
                        div_cnt_s = div_cnt_r;
                    end
                    if (state_r == ST_PHASE) begin
                        if (dly_cnt_r == DLY_W'(0)) begin
                            run_state_s = ST_HIGH;
                            wid_cnt_s   = wid_load_s;
                        end else begin
                            dly_cnt_s = dly_cnt_r - DLY_W'(1);
                        end
                    end else if (wid_cnt_r == WID_W'(0)) begin
                        pulses_s = pulses_inc_s;
                        if (!periodic_r) begin
                            run_state_s = ST_DONE;
                        end else if ((count_r != CNT_W'(0)) && (pulses_inc_s == count_r)) begin
                            run_state_s = ST_DONE;
                        end else begin
                            run_state_s = ST_WAIT_EDGE;
                        end
                    end else begin
                        wid_cnt_s = wid_cnt_r - WID_W'(1);
                    end
                end
                default: begin
                    run_state_s = ST_IDLE;
                end
            endcase
            if (stop_s) begin
                state_s   = ST_IDLE;
                overrun_s = overrun_r;
            end else begin
                state_s   = run_state_s;
            end
            out_s  = (state_s == ST_HIGH) && (width_r != WIDTH_W'(0));
            busy_s = (state_s != ST_IDLE) && (state_s != ST_DONE);
            done_s = (state_s == ST_DONE);
        end

        // Channel state, latched configuration and output registers
        always_ff @(posedge i_clk_10) begin
            if (!i_rst_n) begin
                state_r    <= ST_IDLE;
                div_r      <= DIV_W'(1);
                phase_r    <= PHASE_W'(0);
                width_r    <= WIDTH_W'(0);
                periodic_r <= 1'b0;
                count_r    <= CNT_W'(0);
                div_cnt_r  <= DIV_W'(0);
                pulses_r   <= CNT_W'(0);
                dly_cnt_r  <= DLY_W'(0);
                wid_cnt_r  <= WID_W'(0);
                out_r      <= 1'b0;
                busy_r     <= 1'b0;
                done_r     <= 1'b0;
                overrun_r  <= 1'b0;
            end else begin
                state_r    <= state_s;
                div_r      <= div_s;
                phase_r    <= phase_s;
                width_r    <= width_s;
                periodic_r <= periodic_s;
                count_r    <= count_s;
                div_cnt_r  <= div_cnt_s;
                pulses_r   <= pulses_s;
                dly_cnt_r  <= dly_cnt_s;
                wid_cnt_r  <= wid_cnt_s;
                out_r      <= out_s;
                busy_r     <= busy_s;
                done_r     <= done_s;
                overrun_r  <= overrun_s;
            end
        end

        assign bus.o_pps_divided[ch] = out_r;
        assign bus.o_busy[ch]        = busy_r;
        assign bus.o_done[ch]        = done_r;
        assign bus.o_overrun[ch]     = overrun_r;
    end
endmodule
